// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the 9-bit processor front end: fetch states, the
// branch/jump target table and the opcode constants the fetch unit watches.
package definitions;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int TGT_W = 10;

  localparam logic [4:0] oHALT = 5'b11111;

  // Absolute branch/jump destinations, indexed by the decoder immediate.
  localparam logic [TGT_W-1:0] TARGET [32] = '{
    10'h000, 10'h010, 10'h020, 10'h028, 10'h040, 10'h050, 10'h060, 10'h070,
    10'h080, 10'h090, 10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 10'h0E0, 10'h0F0,
    10'h100, 10'h1A0, 10'h120, 10'h130, 10'h140, 10'h150, 10'h160, 10'h170,
    10'h180, 10'h190, 10'h2A0, 10'h2B0, 10'h1C0, 10'h1D0, 10'h1E0, 10'h3FE
  };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational lookup of an absolute target address from the target table.
import definitions::*;

module branch_lut (
  input  logic [4:0]       idx,
  output logic [TGT_W-1:0] tgt
);

  assign tgt = TARGET[idx];

endmodule

// File: rtl/fetch_unit.sv
// PC register and start/halt sequencer feeding instruction ROM.
// Optional cycle counter is built only when FETCH_CYCLE_COUNT_EN is defined.
import definitions::*;

module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             BranchTaken,
  input  logic [4:0]       Imm,
  input  logic [4:0]       OP,
  output logic [PC_W-1:0]  InstrAddr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       StateDbg
);

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  next_pc;
  logic             running_q;
  logic             done_q;
  logic [4:0]       lut_idx;
  logic [TGT_W-1:0] lut_tgt;
  logic             redirect;

  // Branches only reach the first eight table entries; jumps reach all 32.
  assign lut_idx  = Jump ? Imm : {2'b00, Imm[2:0]};
  assign redirect = Jump | (BranchEn & BranchTaken);

  branch_lut u_lut (
    .idx (lut_idx),
    .tgt (lut_tgt)
  );

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (redirect) next_pc = PC_W'(lut_tgt);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      pc        <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state     <= RUN;
            pc        <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          // Halt outranks stall so a halt during a memory op still stops.
          if (OP == oHALT) begin
            state     <= HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (!Stall) begin
            pc <= next_pc;
          end
        end
        default: begin
          state     <= IDLE;
          pc        <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (state == RUN) begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else if (Start) begin
      cnt <= '0;
    end
  end

  assign CycleCount = cnt;
`else
  assign CycleCount = '0;
`endif

  assign InstrAddr = pc;
  assign Running   = running_q;
  assign Done      = done_q;
  assign StateDbg  = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written reset, halt
// and restart sequences.
module tb_fetch_unit;

  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] HALT = 5'b11111;

  logic        Clk;
  logic        Reset_n;
  logic        Start, Stall, Jump, BranchEn, BranchTaken;
  logic [4:0]  Imm, OP;
  logic [9:0]  InstrAddr;
  logic        Running, Done;
  logic [15:0] CycleCount;
  logic [1:0]  StateDbg;

  int tests_run;
  int tests_failed;

  logic [9:0] exp_q[$];

  typedef struct {
    logic       start, stall, jump, br, tk;
    logic [4:0] imm;
    logic [4:0] op;
    logic [9:0] addr;
    logic       run, done;
  } vec_t;

  vec_t tbl[$];

  fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Stall       (Stall),
    .Jump        (Jump),
    .BranchEn    (BranchEn),
    .BranchTaken (BranchTaken),
    .Imm         (Imm),
    .OP          (OP),
    .InstrAddr   (InstrAddr),
    .Running     (Running),
    .Done        (Done),
    .CycleCount  (CycleCount),
    .StateDbg    (StateDbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic j, input logic b,
                       input logic t, input logic [4:0] im, input logic [4:0] op);
    Start = st; Stall = sl; Jump = j; BranchEn = b; BranchTaken = t; Imm = im; OP = op;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [9:0] a, input logic r, input logic d);
    chk({name, ".addr"}, 32'(InstrAddr), 32'(a));
    chk({name, ".running"}, 32'(Running), 32'(r));
    chk({name, ".done"}, 32'(Done), 32'(d));
  endtask

  logic [15:0] exp_cnt10, exp_cnt1;

  initial begin
    tests_run = 0;
    tests_failed = 0;
`ifdef FETCH_CYCLE_COUNT_EN
    exp_cnt10 = 16'd10;
    exp_cnt1  = 16'd1;
`else
    exp_cnt10 = 16'd0;
    exp_cnt1  = 16'd0;
`endif

    //               st sl j  b  t  imm       op    addr     run done
    tbl.push_back('{1, 0, 0, 0, 0, 5'd0,     NOP,  10'h000, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h001, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h002, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h003, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h004, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h005, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 5'd17,    NOP,  10'h1A0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h1A1, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 5'd3,     NOP,  10'd40,  1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 5'd3,     NOP,  10'd41,  1, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 5'b11011, NOP,  10'd40,  1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 5'd17,    NOP,  10'd40,  1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 5'd17,    NOP,  10'd40,  1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 5'd17,    NOP,  10'h1A0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 5'd0,     NOP,  10'h1A1, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 5'b11011, NOP,  10'h2B0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 5'd31,    NOP,  10'h3FE, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h3FF, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h000, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 5'd0,     NOP,  10'h000, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 5'd0,     HALT, 10'h000, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 5'd0,     NOP,  10'h000, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 5'd17,    NOP,  10'h000, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 5'd0,     NOP,  10'h000, 1, 0});

    drive(0, 0, 0, 0, 0, 5'd0, NOP);
    Reset_n = 1'b0;
    #13;
    Reset_n = 1'b1;
    #1;
    chk_outs("reset", 10'h000, 1'b0, 1'b0);
    chk("reset.count", 32'(CycleCount), 32'd0);

    // Start in the third cycle, run five instructions, then reset between edges.
    step();
    step();
    drive(1, 0, 0, 0, 0, 5'd0, NOP);
    step();
    chk_outs("start", 10'h000, 1'b1, 1'b0);
    drive(0, 0, 0, 0, 0, 5'd0, NOP);
    for (int i = 1; i <= 5; i++) step();
    chk("prereset.addr", 32'(InstrAddr), 32'd5);
    #3;
    Reset_n = 1'b0;
    #1;
    chk_outs("async_reset", 10'h000, 1'b0, 1'b0);
    chk("async_reset.count", 32'(CycleCount), 32'd0);
    #2;
    Reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stall, tbl[i].jump, tbl[i].br, tbl[i].tk, tbl[i].imm, tbl[i].op);
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].addr, tbl[i].run, tbl[i].done);
    end

    // Fresh run from the restart above: nine sequential fetches then halt at PC 9.
    for (int i = 1; i <= 9; i++) exp_q.push_back(10'(i));
    drive(0, 0, 0, 0, 0, 5'd0, NOP);
    while (exp_q.size() > 0) begin
      step();
      chk("seq.addr", 32'(InstrAddr), 32'(exp_q.pop_front()));
    end
    drive(0, 0, 0, 0, 0, 5'd0, HALT);
    step();
    chk_outs("halt9", 10'd9, 1'b0, 1'b1);
    chk("halt9.count", 32'(CycleCount), 32'(exp_cnt10));
    drive(0, 0, 0, 0, 0, 5'd0, NOP);
    step();
    chk_outs("halt9.hold", 10'd9, 1'b0, 1'b1);
    chk("halt9.count_hold", 32'(CycleCount), 32'(exp_cnt10));

    drive(1, 0, 0, 0, 0, 5'd0, NOP);
    step();
    chk_outs("restart", 10'h000, 1'b1, 1'b0);
    chk("restart.count", 32'(CycleCount), 32'd0);
    drive(0, 0, 0, 0, 0, 5'd0, NOP);
    step();
    chk("restart.next", 32'(InstrAddr), 32'd1);
    chk("restart.count1", 32'(CycleCount), 32'(exp_cnt1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the 9-bit processor, sitting directly upstream of the control decoder. It holds the PC that addresses instruction ROM, runs a start/halt/done state machine, and computes the next PC from the decoder's `Jump`, `BranchEn`, `Imm` and `OP` outputs plus the ALU branch flag. Branch and jump targets are absolute addresses taken from a 32-entry target table.

## Interface
Parameters:
- `PC_W`, 10, PC and instruction ROM address width
- `CNT_W`, 16, cycle-counter width (used only with `FETCH_CYCLE_COUNT_EN`)

Ports:
- `Clk`  in  1  single clock, rising edge
- `Reset_n`  in  1  reset, asynchronous, active-low
- `Start`  in  1  one-cycle request to begin execution at PC 0
- `Stall`  in  1  freeze the PC this cycle (multi-cycle memory op)
- `Jump`  in  1  decoder: unconditional jump
- `BranchEn`  in  1  decoder: instruction is a conditional branch
- `BranchTaken`  in  1  ALU flag: branch condition true
- `Imm`  in  5  decoder immediate, used as target-table index
- `OP`  in  5  decoder opcode; `oHALT` stops the machine
- `InstrAddr`  out  PC_W  current PC to instruction ROM
- `Running`  out  1  high in RUN
- `Done`  out  1  high in HALTED
- `CycleCount`  out  CNT_W  cycles spent in RUN

## Operation
- States: IDLE, RUN, HALTED.
- IDLE: PC held at 0. `Start` moves to RUN next edge, with PC = 0.
- RUN: each edge, next PC is chosen by this priority:
  - `OP==oHALT`: go to HALTED, PC holds at the halt address.
  - `Stall`: PC holds. Jump and branch are ignored this cycle.
  - `Jump`: PC = `TARGET[Imm]`.
  - `BranchEn & BranchTaken`: PC = `TARGET[{2'b00,Imm[2:0]}]`.
  - Otherwise: PC + 1, wrapping modulo 2^PC_W (all-ones → 0, no flag).
- `Start` is ignored in RUN.
- HALTED: `Done`=1 and PC holds. `Start` returns to RUN with PC = 0 and `Done` deasserts on the same edge.
- `BranchEn` without `BranchTaken` behaves as PC + 1.
- If `Jump` and `BranchEn` are both asserted (illegal encoding), `Jump` wins.
- Table targets are zero-extended from `TGT_W` to `PC_W`.
- `Reset_n` low at any time (including mid-run) forces IDLE, PC=0, `Running`=0, `Done`=0, `CycleCount`=0.

## Timing
- All outputs are registered, or decoded from state registers only. There is no combinational path from the inputs to `InstrAddr`.
- Reset values: `InstrAddr`=0, `Running`=0, `Done`=0, `CycleCount`=0.
- Start latency: `Start` sampled at edge N gives `Running`=1 and `InstrAddr`=0 after edge N, so the first instruction is decoded in cycle N+1.
- Redirect latency: a jump or taken branch decoded in cycle k puts the target on `InstrAddr` in cycle k+1. There are no bubbles and no delay slot.
- Halt: `Done` rises the cycle after the halt instruction is presented.
- `Reset_n` deassertion is synchronised externally. The block needs no recovery cycles.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined:
  - `CycleCount` increments on every edge spent in RUN, including stalled cycles, and saturates at all-ones.
  - It clears on `Start` and on reset, and holds in HALTED.
- `FETCH_CYCLE_COUNT_EN` undefined: `CycleCount` is tied to 0 and no counter flops are built.

## Structure
- Shared package `definitions` holds:
  - state enum `fetch_state_t` (IDLE, RUN, HALTED)
  - `TGT_W` = 10
  - the 32-entry constant array `TARGET` of branch/jump addresses
  - the existing `oHALT` opcode constant, reused
- One sub-module, `branch_lut`: combinational, 5-bit index in, `TGT_W`-bit target out, reads `TARGET`.

## Test plan
- Reset with Start mid-run: Start at cycle 2, run 5 instructions, pull `Reset_n` low asynchronously → `InstrAddr`=0 and `Running`=0 immediately, before the next edge.
- Sequential run: Start with no redirects → `InstrAddr` steps 0,1,2,3. At PC 1023 the next PC is 0.
- Jump: `TARGET[17]`=0x1A0, `Jump`=1, `Imm`=17 at PC 5 → next `InstrAddr`=0x1A0.
- Branch pair:
  - `BranchEn`=1, `Imm`=3, `BranchTaken`=1, `TARGET[3]`=40 → next PC 40.
  - Same with `BranchTaken`=0 → PC + 1.
  - `Imm`=5'b11011 with `BranchEn` → still uses `TARGET[3]`.
- Stall with jump: `Stall`=1 together with `Jump` for 2 cycles → PC unchanged for both. Jump taken once `Stall`=0 if still presented.
- Halt and restart:
  - `OP`=`oHALT` at PC 9 → `Done`=1, PC holds at 9, and `CycleCount`=10 with the macro defined (0 without).
  - `Start` → PC 0, `Done`=0, `CycleCount` cleared.
